tb_mem_ctrl: RTL and testbench

- Traceback controller for the Viterbi decoder's survivor-decision memory, a single-port synchronous 8x1024 RAM with write-enable and registered read data (one-cycle read latency).
- Stores one 8-bit decision vector per trellis step from the ACS array into a circular buffer.
- After every DEPTH steps, holds off the ACS stream and runs a traceback over the same port, emitting DEPTH decoded bits.
- Sits between the ACS unit and the decoded-bit output.

---
 rtl/tb_mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_tb_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Traceback controller for the Viterbi survivor-decision memory.
//             Writes one decision vector per trellis step into a circular
//             buffer held in an external single-port RAM with one-cycle read
//             latency. Once per block it stalls the ACS stream and walks the
//             survivor path backwards over the same port, emitting DEPTH
//             decoded bits, newest first.
//  Ports    : clk, rst (async, active-low)
//             d_in_valid/d_in/d_in_ready : decision vector stream from ACS
//             tb_state                   : best-metric state at traceback start
//             mem_wr/mem_addr/mem_d_i    : RAM write enable, address, data
//             mem_d_o                    : RAM read data (addr + 1 cycle)
//             dec_bit/dec_valid          : decoded bit stream
//             dec_first/dec_last         : block delimiters
//             busy                       : traceback in progress
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl #(
  parameter int SW     = 3,
  parameter int AW     = 10,
  parameter int TB_LEN = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_in_valid,
  input  logic [2**SW-1:0]  d_in,
  output logic              d_in_ready,
  input  logic [SW-1:0]     tb_state,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [2**SW-1:0]  mem_d_i,
  input  logic [2**SW-1:0]  mem_d_o,
  output logic              dec_bit,
  output logic              dec_valid,
  output logic              dec_first,
  output logic              dec_last,
  output logic              busy
);

  // Reads per traceback, block counter width, fill counter width, and a
  // read counter wide enough to also count the two drain cycles.
  localparam int c_nrd = TB_LEN + DEPTH;
  localparam int c_bw  = $clog2(DEPTH);
  localparam int c_fw  = $clog2(c_nrd + 1);
  localparam int c_rw  = $clog2(c_nrd + 2);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_TB    = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [AW-1:0]   wptr_q,      wptr_d;
  logic [c_bw-1:0] blk_cnt_q,   blk_cnt_d;
  logic [c_fw-1:0] fill_cnt_q,  fill_cnt_d;
  logic [c_rw-1:0] rd_cnt_q,    rd_cnt_d;
  logic            rd_pend_q,   rd_pend_d;
  logic [c_rw-1:0] rd_idx_q,    rd_idx_d;
  logic [SW-1:0]   s_q,         s_d;
  logic            dec_bit_q,   dec_bit_d;
  logic            dec_valid_q, dec_valid_d;
  logic            dec_first_q, dec_first_d;
  logic            dec_last_q,  dec_last_d;

  logic [c_fw-1:0] w_fill_next;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    blk_cnt_d   = blk_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_pend_d   = 1'b0;
    rd_idx_d    = rd_idx_q;
    s_d         = s_q;
    dec_bit_d   = dec_bit_q;
    dec_valid_d = 1'b0;
    dec_first_d = 1'b0;
    dec_last_d  = 1'b0;
    d_in_ready  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = wptr_q;
    mem_d_i     = d_in;
    w_fill_next = (fill_cnt_q == c_fw'(c_nrd)) ? fill_cnt_q : fill_cnt_q + c_fw'(1);

    // Read data for the read issued last cycle is on mem_d_o now. The bit
    // emitted is the MSB of the state the entry belongs to, i.e. the state
    // before stepping back to its predecessor.
    if (rd_pend_q) begin
      s_d = {s_q[SW-2:0], mem_d_o[s_q]};
      if (rd_idx_q >= c_rw'(TB_LEN)) begin
        dec_bit_d   = s_q[SW-1];
        dec_valid_d = 1'b1;
        dec_first_d = (rd_idx_q == c_rw'(TB_LEN));
        dec_last_d  = (rd_idx_q == c_rw'(c_nrd - 1));
      end
    end

    case (state_q)
      ST_FILL: begin
        d_in_ready = 1'b1;
        mem_wr     = d_in_valid;
        if (d_in_valid) begin
          wptr_d     = wptr_q + AW'(1);
          blk_cnt_d  = (blk_cnt_q == c_bw'(DEPTH - 1)) ? '0 : blk_cnt_q + c_bw'(1);
          fill_cnt_d = w_fill_next;
          // Only a block boundary with a full convergence window behind it
          // starts a traceback; the write itself completes this cycle.
          if ((blk_cnt_q == c_bw'(DEPTH - 1)) && (w_fill_next == c_fw'(c_nrd))) begin
            state_d  = ST_TB;
            rd_cnt_d = '0;
          end
        end
      end
      ST_TB: begin
        mem_addr  = wptr_q - AW'(1) - AW'(rd_cnt_q);
        rd_pend_d = 1'b1;
        rd_idx_d  = rd_cnt_q;
        rd_cnt_d  = rd_cnt_q + c_rw'(1);
        // First traceback cycle: no read data in flight yet, so the start
        // state is loaded here and used by the first returning read.
        if (rd_cnt_q == '0) begin
          s_d = tb_state;
        end
        if (rd_cnt_q == c_rw'(c_nrd - 1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Two idle cycles let the last read return and its bit register.
        rd_cnt_d = rd_cnt_q + c_rw'(1);
        if (rd_cnt_q == c_rw'(c_nrd + 1)) begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      wptr_q      <= '0;
      blk_cnt_q   <= '0;
      fill_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      s_q         <= '0;
      dec_bit_q   <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_first_q <= 1'b0;
      dec_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      blk_cnt_q   <= blk_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      s_q         <= s_d;
      dec_bit_q   <= dec_bit_d;
      dec_valid_q <= dec_valid_d;
      dec_first_q <= dec_first_d;
      dec_last_q  <= dec_last_d;
    end
  end

  assign dec_bit   = dec_bit_q;
  assign dec_valid = dec_valid_q;
  assign dec_first = dec_first_q;
  assign dec_last  = dec_last_q;
  assign busy      = (state_q != ST_FILL);

endmodule
`default_nettype wire

// File: tb/tb_tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tb_mem_ctrl
//  Purpose  : Self-checking bench for tb_mem_ctrl. Decision vectors come from
//             a trellis path driven by random input bits, so the correct
//             decoded output is simply the input bits themselves. A RAM model
//             with one-cycle read latency is attached to the memory port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tb_mem_ctrl;

  localparam int SW       = 3;
  localparam int AW       = 10;
  localparam int TB_LEN   = 32;
  localparam int DEPTH    = 64;
  localparam int NRD      = TB_LEN + DEPTH;
  localparam int BUSY_LEN = NRD + 2;
  localparam int FIRST_K  = TB_LEN + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_in_valid;
  logic [7:0]    d_in;
  logic          d_in_ready;
  logic [SW-1:0] tb_state;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_d_i;
  logic [7:0]    mem_d_o;
  logic          dec_bit, dec_valid, dec_first, dec_last, busy;

  always #5 clk = ~clk;

  tb_mem_ctrl #(.SW(SW), .AW(AW), .TB_LEN(TB_LEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .d_in_valid(d_in_valid), .d_in(d_in), .d_in_ready(d_in_ready),
    .tb_state(tb_state),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_d_i(mem_d_i), .mem_d_o(mem_d_o),
    .dec_bit(dec_bit), .dec_valid(dec_valid), .dec_first(dec_first),
    .dec_last(dec_last), .busy(busy)
  );

  // Single-port RAM, registered read data.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_d_i;
    mem_d_o <= ram[mem_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- stimulus: trellis path generator ----------------
  logic [2:0] cur_state = 3'd0;
  logic       u_p;
  logic [2:0] ns_p;
  logic [7:0] d_p;
  bit         zero_mode = 1'b1;
  bit         acc = 1'b0;
  assign tb_state = cur_state;

  // New state shifts the input bit in at the MSB; the decision stored for
  // the new state is the bit that fell out of the old state's LSB.
  task automatic new_vec();
    u_p  = zero_mode ? 1'b0 : 1'($urandom_range(0, 1));
    ns_p = {u_p, cur_state[2:1]};
    d_p  = zero_mode ? 8'h00 : 8'($urandom);
    d_p[ns_p] = cur_state[0];
  endtask

  task automatic drive(input bit v);
    @(posedge clk); #1;
    if (acc) begin
      cur_state = ns_p;
      new_vec();
    end
    d_in_valid = v;
    d_in       = d_p;
  endtask

  // ---------------- reference model (per-cycle prediction) ----------------
  int         m_wcnt = 0;
  logic [9:0] m_wptr = '0;
  int         m_k = -1;          // -1: accepting writes, else traceback cycle
  logic [9:0] m_base = '0;
  int         n_blocks = 0;
  bit         exp_q[$];
  bit         exp_u [0:1023];
  logic [7:0] exp_mem [0:1023];

  always @(negedge clk) begin
    logic [9:0] a;
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_dec_bit", dec_bit, 0);
      chk("rst_dec_first", dec_first, 0);
      chk("rst_dec_last", dec_last, 0);
      chk("rst_mem_wr", mem_wr, 0);
      m_wcnt = 0; m_wptr = '0; m_k = -1; acc = 1'b0;
      exp_q.delete();
    end else if (m_k < 0) begin
      chk("fill_busy", busy, 0);
      chk("fill_ready", d_in_ready, 1);
      chk("fill_dec_valid", dec_valid, 0);
      chk("fill_mem_wr", mem_wr, d_in_valid);
      chk("fill_addr", mem_addr, m_wptr);
      acc = d_in_valid;
      if (d_in_valid) begin
        chk("wr_data", mem_d_i, d_in);
        exp_mem[m_wptr] = d_in;
        exp_u[m_wptr]   = u_p;
        m_wptr++;
        m_wcnt++;
        if ((m_wcnt % DEPTH == 0) && (m_wcnt >= NRD)) begin
          m_k    = 0;
          m_base = m_wptr - 10'd1;
          n_blocks++;
          for (int j = TB_LEN; j < NRD; j++) begin
            a = m_base - 10'(j);
            exp_q.push_back(exp_u[a]);
          end
        end
      end
    end else begin
      acc = 1'b0;
      chk("tb_busy", busy, 1);
      chk("tb_ready", d_in_ready, 0);
      chk("tb_mem_wr", mem_wr, 0);
      if (m_k < NRD) begin
        a = m_base - 10'(m_k);
        chk("tb_addr", mem_addr, a);
      end
      chk("dec_valid", dec_valid, m_k >= FIRST_K);
      if (m_k >= FIRST_K) begin
        chk("dec_first", dec_first, m_k == FIRST_K);
        chk("dec_last", dec_last, m_k == BUSY_LEN - 1);
        if (exp_q.size() > 0) chk("dec_bit", dec_bit, exp_q.pop_front());
      end
      m_k++;
      if (m_k == BUSY_LEN) begin
        m_k = -1;
        chk("block_drained", exp_q.size(), 0);
      end
    end
  end

  // ---------------- table vectors for the idle/fill path ----------------
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       exp_wr;
    logic [9:0] exp_addr;
  } vec_t;
  vec_t tbl [8];

  task automatic wait_idle(input string name);
    int g = 0;
    while (m_k >= 0 && g < 300) begin
      drive(1'b0);
      g++;
    end
    chk(name, m_k < 0, 1);
  endtask

  initial begin
    int g;
    int bad;
    tbl[0] = '{1'b1, 8'h3C, 1'b1, 10'd0};
    tbl[1] = '{1'b0, 8'hFF, 1'b0, 10'd1};
    tbl[2] = '{1'b1, 8'hA5, 1'b1, 10'd1};
    tbl[3] = '{1'b1, 8'h00, 1'b1, 10'd2};
    tbl[4] = '{1'b0, 8'h12, 1'b0, 10'd3};
    tbl[5] = '{1'b1, 8'hFF, 1'b1, 10'd3};
    tbl[6] = '{1'b1, 8'h81, 1'b1, 10'd4};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 10'd5};

    rst = 1'b1; d_in_valid = 1'b0; d_in = 8'h00;
    new_vec();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);   // idle: no writes without valid
    #1;

    for (int i = 0; i < 8; i++) begin
      d_in_valid = tbl[i].v;
      d_in       = tbl[i].d;
      #1;
      chk("tbl_ready", d_in_ready, 1);
      chk("tbl_busy", busy, 0);
      chk("tbl_mem_wr", mem_wr, tbl[i].exp_wr);
      chk("tbl_addr", mem_addr, tbl[i].exp_addr);
      chk("tbl_wdata", mem_d_i, tbl[i].d);
      @(posedge clk); #1;
    end
    d_in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].v) chk("tbl_ram", ram[tbl[i].exp_addr], tbl[i].d);
    end

    // Fresh start: all-zero decisions from state 0.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    zero_mode = 1'b1;
    cur_state = 3'd0;
    new_vec();
    g = 0;
    while (m_wcnt < 2 * DEPTH && g < 1000) begin
      drive($urandom_range(0, 3) != 0);
      g++;
    end
    chk("zero_reach", m_wcnt >= 2 * DEPTH, 1);
    zero_mode = 1'b0;
    wait_idle("zero_tb_done");
    chk("zero_blocks", n_blocks, 1);

    // Random path, address wrap, and a stretch of continuous valid.
    g = 0;
    while (m_wcnt < 1160 && g < 8000) begin
      drive((m_wcnt >= 400 && m_wcnt < 600) ? 1'b1 : ($urandom_range(0, 3) != 0));
      g++;
    end
    chk("rand_reach", m_wcnt >= 1160, 1);
    wait_idle("rand_tb_done");
    chk("rand_blocks", n_blocks, 17);
    bad = 0;
    for (int a = 0; a < 1024; a++) if (ram[a] !== exp_mem[a]) bad++;
    chk("mem_contents", bad, 0);

    // Abort a traceback with reset at cycle 40.
    g = 0;
    while (m_k != 40 && g < 1000) begin
      drive(1'b1);
      g++;
    end
    chk("reach_tb40", m_k, 40);
    rst = 1'b0;
    d_in_valid = 1'b0;
    #1;
    chk("abort_dec_valid", dec_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    g = 0;
    while (m_wcnt < 2 * DEPTH + 2 && g < 1000) begin
      drive($urandom_range(0, 3) != 0);
      g++;
    end
    chk("post_rst_reach", m_wcnt >= 2 * DEPTH + 2, 1);
    wait_idle("post_rst_tb_done");
    chk("post_rst_blocks", n_blocks, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
